// File: rtl/seq_input_stage.sv
// seq_input_stage: synchronizes and debounces two switches, then steps a 2-bit state register from the downstream next-state logic
module seq_input_stage #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_x2,
  input  logic       sw_x1,
  input  logic       ny2,
  input  logic       ny1,
  output logic       x2,
  output logic       x1,
  output logic       y2,
  output logic       y1,
  output logic       step,
  output logic [7:0] sym_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] s1, s2, cand;
  logic [CW-1:0] cnt;
  logic pend, load;
  assign load = (s2 == cand) && (cand != {x2, x1}) && (cnt == LAST);
  assign step = pend;
  // two-flop synchronizer for both raw switch levels
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {sw_x2, sw_x1};
      s2 <= s1;
    end
  // whole-vector debounce: any movement restarts the count, a full stable window accepts cand
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cand <= '0;
      cnt <= '0;
      {x2, x1} <= '0;
      pend <= 1'b0;
    end else begin
      cand <= s2;
      pend <= load;
      if (load) {x2, x1} <= cand;
      cnt <= (s2 != cand || cand == {x2, x1} || load) ? '0 : cnt + 1'b1;
    end
  // state load one cycle after x settles, plus saturating symbol count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {y2, y1} <= '0;
      sym_count <= '0;
    end else if (pend) begin
      {y2, y1} <= {ny2, ny1};
      if (sym_count != 8'hff) sym_count <= sym_count + 8'd1;
    end
endmodule

// File: tb/tb_seq_input_stage.sv
// tb_seq_input_stage: directed stimulus with a sample-history model of the debounced stage
module tb_seq_input_stage;
  localparam int D = 4;
  logic clk = 0, rst_n = 1, sw_x2 = 0, sw_x1 = 0;
  logic x2, x1, y2, y1, step, ny2, ny1, z;
  logic [7:0] sym_count;
  int total = 0, bad = 0, stepcnt = 0, s0;
  bit run = 0;
  assign ny1 = x1 | x2 & y1;
  assign ny2 = x2 & ~x1 & ~y1 | x1 & x2 & y2;
  assign z = y1 & y2;
  seq_input_stage #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .sw_x2(sw_x2), .sw_x1(sw_x1), .ny2(ny2), .ny1(ny1),
    .x2(x2), .x1(x1), .y2(y2), .y1(y1), .step(step), .sym_count(sym_count)
  );
  always #5 if (run) clk = ~clk;
  task automatic chk(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", n, act, exp, $time);
    end
  endtask
  // model: raw samples per edge; x takes a value once D+1 consecutive samples, ending two edges back, agree and differ from x
  logic [1:0] q[$];
  logic [1:0] xm, ym, v;
  logic pm;
  int cm;
  bit ok;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q = {};
      repeat (D + 3) q.push_front(2'b00);
      xm = 0; ym = 0; pm = 0; cm = 0;
    end else begin
      q.push_front({sw_x2, sw_x1});
      void'(q.pop_back());
      if (pm) begin
        ym = {xm[1] & ~xm[0] & ~ym[0] | xm[0] & xm[1] & ym[1], xm[0] | xm[1] & ym[0]};
        if (cm < 255) cm++;
        pm = 0;
      end
      v = q[2];
      ok = (v != xm);
      for (int i = 3; i <= D + 2; i++) if (q[i] != v) ok = 0;
      if (ok) begin
        xm = v;
        pm = 1;
      end
    end
  always @(negedge clk) begin
    chk("x", {x2, x1}, xm);
    chk("y", {y2, y1}, ym);
    chk("step", step, pm);
    chk("sym", sym_count, cm);
  end
  always @(posedge clk) if (step) stepcnt++;
  task automatic rst();
    @(negedge clk);
    sw_x2 = 0; sw_x1 = 0;
    #2 rst_n = 0;
    #1 chk("rst", {x2, x1, y2, y1, step, sym_count}, 0);
    @(negedge clk) rst_n = 1;
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    #2 rst_n = 0;
    #1 chk("async_rst", {x2, x1, y2, y1, step, sym_count}, 0);
    #5 rst_n = 1;
    run = 1;
    @(negedge clk) sw_x2 = 1;
    cyc(3); sw_x2 = 0;
    cyc(20);
    chk("bounce_x", {x2, x1}, 0);
    chk("bounce_sym", sym_count, 0);
    chk("bounce_steps", stepcnt, 0);
    rst();
    sw_x2 = 1;
    cyc(6); chk("e6_x2", x2, 0);
    cyc(1); chk("e7_x2", x2, 1); chk("e7_step", step, 1);
    cyc(1); chk("e8_step", step, 0); chk("e8_y", {y2, y1}, 2);
    cyc(20); sw_x1 = 1;
    cyc(12);
    chk("seq_x", {x2, x1}, 3); chk("seq_y", {y2, y1}, 3);
    chk("seq_z", z, 1); chk("seq_sym", sym_count, 2);
    rst();
    s0 = stepcnt;
    sw_x2 = 1; sw_x1 = 1;
    cyc(12);
    chk("both_steps", stepcnt - s0, 1); chk("both_x", {x2, x1}, 3); chk("both_sym", sym_count, 1);
    rst();
    sw_x2 = 1; sw_x1 = 1;
    s0 = stepcnt;
    cyc(5);
    #2 rst_n = 0;
    #1 chk("mid_rst", {x2, x1, y2, y1, step, sym_count}, 0);
    @(negedge clk) rst_n = 1;
    cyc(7); chk("pre_step", step, 1);
    #2 rst_n = 0;
    #1 chk("step_rst", {x2, x1, y2, y1, step, sym_count}, 0);
    @(negedge clk) rst_n = 1;
    cyc(12);
    chk("fresh_steps", stepcnt - s0, 1); chk("fresh_x", {x2, x1}, 3);
    chk("fresh_y", {y2, y1}, 1); chk("fresh_sym", sym_count, 1);
    rst();
    for (int i = 0; i < 260; i++) begin
      sw_x1 = ~sw_x1;
      cyc(12);
    end
    chk("sat_sym", sym_count, 255);
    chk("sat_steps", stepcnt - s0, 261);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_input_stage.md
SEQ_INPUT_STAGE -- requirements
Module: seq_input_stage

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), SHALL set the number of consecutive stable cycles needed to accept an input change; legal range >= 2.
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 sw_x2, sw_x1  input  1 each  SHALL be raw, asynchronous slide-switch levels.
REQ-005 ny2, ny1  input  1 each  SHALL be next-state bits returned by the downstream combinational stage, computed from x2, x1, y2 and y1.
REQ-006 x2, x1  output  1 each  SHALL be the debounced input symbol presented to the combinational stage.
REQ-007 y2, y1  output  1 each  SHALL be the registered machine state presented to the combinational stage.
REQ-008 step  output  1  SHALL be a one-cycle pulse marking the cycle in which y loads ny.
REQ-009 sym_count  output  8  SHALL be the number of accepted input symbols.

Function
REQ-010 Each raw switch SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-011 A 2-bit candidate register cand SHALL capture {s2_x2, s2_x1} every cycle.
REQ-012 Debounce SHALL act on the 2-bit vector as a whole, using a counter cnt of width $clog2(DEBOUNCE_CYCLES).
REQ-013 Each edge, if the synchronized vector differs from cand, cnt SHALL clear to 0.
REQ-014 Otherwise, if cand differs from {x2,x1} and cnt == DEBOUNCE_CYCLES-1, {x2,x1} SHALL load cand and cnt SHALL clear.
REQ-015 Otherwise, if cand differs from {x2,x1}, cnt SHALL increment.
REQ-016 If cand equals {x2,x1}, cnt SHALL hold at 0.
REQ-017 Latency: a clean raw change, stable throughout, SHALL appear on x2/x1 after exactly DEBOUNCE_CYCLES+3 rising edges, counting the first sampling edge as 1.
REQ-018 A bounce that returns to the current x value before the threshold SHALL produce no x change and no step.
REQ-019 Both bits changing in the same or in overlapping windows SHALL yield one symbol, accepted when the full 2-bit value has been stable for the threshold.
REQ-020 Load flag: on the edge that updates x, a pending flag SHALL set; step SHALL equal this flag, giving one cycle of step.
REQ-021 On the next edge, {y2,y1} SHALL load {ny2,ny1} and the flag SHALL clear, so ny is sampled one cycle after x settles.
REQ-022 {y2,y1} SHALL change only on an edge where step=1.
REQ-023 Two steps SHALL be separated by at least DEBOUNCE_CYCLES cycles; a new x update SHALL never occur while step=1.
REQ-024 sym_count SHALL increment on each step edge, saturating at 255 without wrap.

Reset
REQ-025 While rst_n=0, all flops SHALL clear immediately, independent of clk: s1, s2, cand, cnt, x2, x1, y2, y1, pending flag/step and sym_count.
REQ-026 Assertion mid-debounce or during step SHALL discard the in-progress change; no y load SHALL occur.
REQ-027 After release, a switch held high SHALL be accepted as a normal change, with DEBOUNCE_CYCLES+3 edges latency and one step.

Verification (DEBOUNCE_CYCLES=4; bench closes the loop with the combinational stage ny1=x1|x2&y1, ny2=x2&~x1&~y1|x1&x2&y2, z=y1&y2)
REQ-028 Reset pulse with clk stopped -> all outputs 0 asynchronously; step stays 0.
REQ-029 sw_x2 high for 3 cycles, then low -> x stays 00, no step, sym_count 0.
REQ-030 Clean sequence 00->10, then after 20 cycles ->11:
- x2 rises on edge 7; step high for one cycle; y=10 after edge 8.
- Then x=11, y=11, z=1, sym_count=2.
REQ-031 sw_x2 and sw_x1 rise in the same cycle -> exactly one step, x=11, sym_count=1.
REQ-032 rst_n low at cnt=2 and again during step -> outputs 0 at once; no y load; after release with switches held, one fresh step.
REQ-033 260 alternating accepted symbols -> sym_count stops at 255.
